image_line_feeder: RTL and testbench

Streams a stored greyscale image from frame RAM into the line-buffer window generator, one 8-bit pixel per cycle, with line-level flow control. It preloads the first lines back-to-back. After that, each line-done interrupt from the window generator grants exactly one more line. It sits between the frame memory (or DMA landing buffer) and the pixel input of the 3x3 window generator.

---
 rtl/image_feed_pkg.sv | 16 +
 rtl/line_credit_counter.sv | 46 ++++
 rtl/image_line_feeder.sv | 135 +++++++++++++
 tb/tb_image_line_feeder.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/image_feed_pkg.sv
// rtl/image_feed_pkg.sv - shared state encoding and default geometry for the image line feeder
package image_feed_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT,
        ST_FLUSH
    } feed_state_t;

    localparam int CREDIT_W       = 4;
    localparam int CREDIT_MAX     = 15;
    localparam int DEF_LINE_WIDTH = 512;
    localparam int DEF_IMG_LINES  = 512;

endpackage

// File: rtl/line_credit_counter.sv
// rtl/line_credit_counter.sv - saturating up/down line credit counter
// o_nonzero reflects the value after this cycle's update so callers can decide without a bubble.
module line_credit_counter
    import image_feed_pkg::*;
#(
    parameter int W   = CREDIT_W,
    parameter int MAX = CREDIT_MAX
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_inc,
    input  logic         i_dec,
    output logic         o_nonzero
);

    logic [W-1:0] r_count;
    logic [W-1:0] w_next;

    always_comb begin
        w_next = r_count;
        if (i_load) begin
            w_next = i_load_val;
        end else if (i_inc && !i_dec) begin
            if (r_count != W'(MAX)) begin
                w_next = r_count + 1'b1;
            end
        end else if (i_dec && !i_inc) begin
            if (r_count != '0) begin
                w_next = r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else begin
            r_count <= w_next;
        end
    end

    assign o_nonzero = (w_next != '0);

endmodule

// File: rtl/image_line_feeder.sv
// rtl/image_line_feeder.sv - streams frame RAM lines to the window generator under line credits
// Image lines read RAM; pad lines emit zeros with identical valid timing.
module image_line_feeder
    import image_feed_pkg::*;
#(
    parameter int LINE_WIDTH    = DEF_LINE_WIDTH,
    parameter int IMG_LINES     = DEF_IMG_LINES,
    parameter int PRELOAD_LINES = 4,
    parameter int PAD_LINES     = 0,
    parameter int ADDR_W        = 18
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_intr,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_rd,
    input  logic [7:0]        i_mem_rdata,
    output logic [7:0]        o_pixel_data,
    output logic              o_pixel_data_valid,
    output logic              o_busy,
    output logic              o_done
);

    localparam int TOTAL_LINES = IMG_LINES + PAD_LINES;
    localparam int COL_W       = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
    localparam int LINE_W      = $clog2(TOTAL_LINES + 1);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(LINE_WIDTH - 1);
    localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(TOTAL_LINES - 1);
    localparam logic [LINE_W-1:0] IMG_END   = LINE_W'(IMG_LINES);

    feed_state_t        r_state;
    feed_state_t        w_state_next;
    logic [COL_W-1:0]   r_col;
    logic [LINE_W-1:0]  r_line;
    logic [LINE_W-1:0]  w_line_next;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_valid;
    logic               r_img;
    logic               r_done;
    logic               w_issue;
    logic               w_line_end;
    logic               w_credit_inc;
    logic               w_credit_load;
    logic               w_credit_ok;
    logic               w_next_rd;

    assign w_issue       = (r_state == ST_SEND);
    assign w_line_end    = w_issue && (r_col == COL_LAST);
    assign w_credit_inc  = i_intr && ((r_state == ST_SEND) || (r_state == ST_WAIT));
    assign w_credit_load = (r_state == ST_IDLE) && i_start;

    line_credit_counter #(
        .W   (CREDIT_W),
        .MAX (CREDIT_MAX)
    ) u_credit (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_credit_load),
        .i_load_val (CREDIT_W'(PRELOAD_LINES)),
        .i_inc      (w_credit_inc),
        .i_dec      (w_line_end),
        .o_nonzero  (w_credit_ok)
    );

    always_comb begin
        w_state_next = r_state;
        w_line_next  = r_line;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_next = ST_SEND;
                    w_line_next  = '0;
                end
            end
            ST_SEND: begin
                if (w_line_end) begin
                    w_line_next = r_line + 1'b1;
                    if (r_line == LINE_LAST) begin
                        w_state_next = ST_FLUSH;
                    end else if (!w_credit_ok) begin
                        w_state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (w_credit_ok) begin
                    w_state_next = ST_SEND;
                end
            end
            ST_FLUSH: w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Address holds the last issued read; it advances only when another image read follows.
    assign w_next_rd = (w_state_next == ST_SEND) && (w_line_next < IMG_END);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_col   <= '0;
            r_line  <= '0;
            r_addr  <= '0;
            r_valid <= 1'b0;
            r_img   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_line  <= w_line_next;
            r_valid <= w_issue;
            r_img   <= o_mem_rd;
            r_done  <= (r_state == ST_FLUSH);
            if (w_credit_load) begin
                r_col  <= '0;
                r_addr <= '0;
            end else begin
                if (w_issue) begin
                    r_col <= w_line_end ? '0 : r_col + 1'b1;
                end
                if (w_next_rd) begin
                    r_addr <= r_addr + 1'b1;
                end
            end
        end
    end

    assign o_mem_rd           = w_issue && (r_line < IMG_END);
    assign o_mem_addr         = r_addr;
    assign o_pixel_data_valid = r_valid;
    assign o_pixel_data       = (r_valid && r_img) ? i_mem_rdata : 8'h00;
    assign o_busy             = (r_state != ST_IDLE);
    assign o_done             = r_done;

endmodule

// File: tb/tb_image_line_feeder.sv
// tb/tb_image_line_feeder.sv - scoreboard bench for image_line_feeder
module tb_image_line_feeder;

    localparam int LW   = 8;
    localparam int IL   = 6;
    localparam int PL   = 4;
    localparam int PADL = 2;
    localparam int AW   = 8;
    localparam int NPIX = LW * (IL + PADL);

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          start = 1'b0;
    logic          intr  = 1'b0;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic [7:0]    mem_rdata;
    logic [7:0]    pix;
    logic          pix_v;
    logic          busy;
    logic          done;

    image_line_feeder #(
        .LINE_WIDTH    (LW),
        .IMG_LINES     (IL),
        .PRELOAD_LINES (PL),
        .PAD_LINES     (PADL),
        .ADDR_W        (AW)
    ) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_start            (start),
        .i_intr             (intr),
        .o_mem_addr         (mem_addr),
        .o_mem_rd           (mem_rd),
        .i_mem_rdata        (mem_rdata),
        .o_pixel_data       (pix),
        .o_pixel_data_valid (pix_v),
        .o_busy             (busy),
        .o_done             (done)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous RAM: data = addr[7:0] one cycle after a read, garbage otherwise.
    always @(posedge clk) mem_rdata <= mem_rd ? mem_addr[7:0] : 8'($urandom);

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [7:0]    exp_pix[$];
    logic [AW-1:0] exp_addr[$];
    int            valid_cnt = 0;
    int            rd_cnt    = 0;
    int            done_cnt  = 0;
    int            last_valid_cyc = -10;
    int            vcyc[NPIX];
    int            st_cyc = 0;

    task automatic check(input bit ok, input string name, input longint act, input longint exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_eq(input string name, input longint act, input longint exp);
        check(act == exp, name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic monitor_loop();
        forever begin
            @(negedge clk);
            if (rst || (start && !busy)) begin
                valid_cnt      = 0;
                rd_cnt         = 0;
                last_valid_cyc = -10;
            end
            if (pix_v) begin
                check(exp_pix.size() != 0, "unexpected_valid", 1, 0);
                if (exp_pix.size() != 0) begin
                    logic [7:0] e;
                    e = exp_pix.pop_front();
                    check_eq("pixel_data", pix, e);
                end
                if (valid_cnt < NPIX) vcyc[valid_cnt] = cyc;
                valid_cnt++;
                last_valid_cyc = cyc;
            end
            if (mem_rd) begin
                check(exp_addr.size() != 0, "unexpected_read", 1, 0);
                if (exp_addr.size() != 0) begin
                    logic [AW-1:0] a;
                    a = exp_addr.pop_front();
                    check_eq("read_addr", mem_addr, a);
                end
                rd_cnt++;
            end
            if (done) begin
                done_cnt++;
                check_eq("done_after_last_valid", cyc - last_valid_cyc, 1);
                check_eq("busy_low_at_done", busy, 0);
                check_eq("pixels_left_at_done", exp_pix.size(), 0);
            end
        end
    endtask

    task automatic start_frame();
        for (int i = 0; i < NPIX; i++) exp_pix.push_back((i < LW * IL) ? 8'(i) : 8'h00);
        for (int i = 0; i < LW * IL; i++) exp_addr.push_back(AW'(i));
        start  = 1'b1;
        st_cyc = cyc;
        tick();
        start  = 1'b0;
    endtask

    task automatic pulse_intr();
        intr = 1'b1;
        tick();
        intr = 1'b0;
    endtask

    task automatic wait_valid(input int n, input int budget);
        int k = 0;
        while (valid_cnt < n && k < budget) begin
            tick();
            k++;
        end
        check(valid_cnt >= n, "wait_valid_timeout", valid_cnt, n);
    endtask

    task automatic wait_done(input int budget);
        int d0 = done_cnt;
        int k = 0;
        while (done_cnt == d0 && k < budget) begin
            tick();
            k++;
        end
        check(done_cnt != d0, "wait_done_timeout", done_cnt, d0 + 1);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_valid"}, pix_v, 0);
        check_eq({tag, "_pix"},   pix, 0);
        check_eq({tag, "_rd"},    mem_rd, 0);
        check_eq({tag, "_addr"},  mem_addr, 0);
        check_eq({tag, "_busy"},  busy, 0);
        check_eq({tag, "_done"},  done, 0);
    endtask

    // Feed the four remaining credits; randomly either let the feeder stall or overlap grants.
    task automatic grant_rest_random();
        int granted = PL;
        for (int k = 0; k < 4; k++) begin
            if ($urandom_range(0, 1) == 1) begin
                wait_valid(LW * granted, 200);
                repeat ($urandom_range(0, 10)) tick();
                check_eq("stall_at_granted", valid_cnt, LW * granted);
            end else begin
                repeat ($urandom_range(0, 6)) tick();
                check(valid_cnt <= LW * granted, "never_exceeds_granted", valid_cnt, LW * granted);
            end
            pulse_intr();
            granted++;
        end
        wait_done(300);
        check_eq("frame_valids", valid_cnt, NPIX);
    endtask

    initial begin
        int t;
        int d0;
        int k;
        fork
            monitor_loop();
            begin
                #400000;
                $display("FAIL watchdog: simulation did not finish");
                $fatal(1);
            end
        join_none

        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();
        check_all_zero("post_reset");

        // Preload, then hold in WAIT
        d0 = done_cnt;
        start_frame();
        repeat (45) tick();
        check_eq("preload_valids", valid_cnt, PL * LW);
        check_eq("first_valid_latency", vcyc[0] - st_cyc, 2);
        check_eq("preload_contiguous", vcyc[PL * LW - 1] - vcyc[0], PL * LW - 1);
        check_eq("wait_addr_hold", mem_addr, PL * LW - 1);
        check_eq("wait_rd_low", mem_rd, 0);
        check_eq("wait_busy", busy, 1);
        check_eq("no_done_in_wait", done_cnt, d0);
        t = cyc;
        pulse_intr();
        repeat (12) tick();
        check_eq("intr_to_valid", vcyc[32] - t, 2);
        check_eq("line5_valids", valid_cnt, 40);
        t = cyc;
        pulse_intr();
        repeat (12) tick();
        check_eq("intr2_to_valid", vcyc[40] - t, 2);
        check_eq("line6_valids", valid_cnt, 48);
        pulse_intr();
        pulse_intr();
        wait_done(60);
        check_eq("frame_a_valids", valid_cnt, NPIX);
        check_eq("frame_a_reads", rd_cnt, LW * IL);
        check_eq("pad_contiguous", vcyc[NPIX - 1] - vcyc[LW * IL], LW * PADL - 1);
        check_eq("pad_addr_hold", mem_addr, LW * IL - 1);
        tick();
        check_eq("idle_busy", busy, 0);

        // Credit granted on the last preload pixel: no bubble, net credit unchanged
        start_frame();
        k = 0;
        while (!(mem_rd && mem_addr == AW'(31)) && k < 60) begin
            tick();
            k++;
        end
        check(k < 60, "find_last_preload_pixel", k, 60);
        intr = 1'b1;
        tick();
        intr = 1'b0;
        repeat (20) tick();
        check_eq("no_bubble", vcyc[32] - vcyc[31], 1);
        check_eq("net_credit_unchanged", valid_cnt, 40);
        for (int i = 0; i < 3; i++) begin
            repeat ($urandom_range(1, 10)) tick();
            pulse_intr();
        end
        wait_done(100);
        check_eq("frame_b_valids", valid_cnt, NPIX);

        // Credit flood with an ignored mid-frame start
        start_frame();
        for (int i = 0; i < 20; i++) begin
            if (i == 10) start = 1'b1;
            pulse_intr();
            start = 1'b0;
        end
        wait_done(120);
        check_eq("flood_valids", valid_cnt, NPIX);
        check_eq("flood_contiguous", vcyc[NPIX - 1] - vcyc[0], NPIX - 1);
        check_eq("flood_reads", rd_cnt, LW * IL);

        // Randomized credit timing
        for (int f = 0; f < 4; f++) begin
            repeat ($urandom_range(1, 5)) tick();
            start_frame();
            grant_rest_random();
        end

        // Asynchronous reset mid-line, then restart
        start_frame();
        wait_valid(13, 60);
        #2 rst = 1'b1;
        #1;
        check_all_zero("async_reset");
        exp_pix.delete();
        exp_addr.delete();
        tick();
        rst = 1'b0;
        repeat (20) tick();
        check_eq("no_valid_after_reset", valid_cnt, 0);
        check_eq("idle_after_reset", busy, 0);
        start_frame();
        grant_rest_random();
        check_eq("restart_latency", vcyc[0] - st_cyc, 2);

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
